// File: rtl/sfp_link_supervisor_pkg.sv
// ---------------------------------------------------------------------------
// sfp_link_supervisor_pkg
// Shared types and defaults for the SFP link supervisor:
//   t_sfp_link_state  - supervisor FSM states
//   t_link_outputs    - registered control outputs decoded from the state
//   DEF_*             - default parameter values (40 MHz GBT clock)
//   LOSS_COUNT_W      - width of the loss event counter
// Optional feature macro used by the importing RTL: SFP_LINK_STATS_EN.
// ---------------------------------------------------------------------------
package sfp_link_supervisor_pkg;

    typedef enum logic [2:0] {
        DISABLED,
        TX_RESET,
        WAIT_SIGNAL,
        WAIT_LOCK,
        UP,
        FAULT
    } t_sfp_link_state;

    localparam int unsigned DEF_LOS_FILTER_CYCLES   = 4000;      // 100 us
    localparam int unsigned DEF_TX_DISABLE_CYCLES   = 400;       // 10 us
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 4_000_000; // 100 ms
    localparam int unsigned DEF_MAX_RETRIES         = 8;
    localparam int unsigned LOSS_COUNT_W            = 16;

    typedef struct packed {
        logic tx_disable;
        logic link_reset;
        logic link_up;
        logic fault;
    } t_link_outputs;

    function automatic t_link_outputs decode_outputs(input t_sfp_link_state s);
        t_link_outputs o;
        o = '{tx_disable: 1'b1, link_reset: 1'b1, link_up: 1'b0, fault: 1'b0};
        case (s)
            DISABLED:    o = '{tx_disable: 1'b1, link_reset: 1'b1, link_up: 1'b0, fault: 1'b0};
            TX_RESET:    o = '{tx_disable: 1'b1, link_reset: 1'b1, link_up: 1'b0, fault: 1'b0};
            WAIT_SIGNAL: o = '{tx_disable: 1'b0, link_reset: 1'b1, link_up: 1'b0, fault: 1'b0};
            WAIT_LOCK:   o = '{tx_disable: 1'b0, link_reset: 1'b0, link_up: 1'b0, fault: 1'b0};
            UP:          o = '{tx_disable: 1'b0, link_reset: 1'b0, link_up: 1'b1, fault: 1'b0};
            FAULT:       o = '{tx_disable: 1'b1, link_reset: 1'b1, link_up: 1'b0, fault: 1'b1};
            default:     o = '{tx_disable: 1'b1, link_reset: 1'b1, link_up: 1'b0, fault: 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sfp_los_filter.sv
// ---------------------------------------------------------------------------
// sfp_los_filter
// Synchronises the asynchronous SFP loss-of-signal pin with a 2-FF
// synchroniser and debounces it: the filtered level only follows the
// synchronised input after LOS_FILTER_CYCLES consecutive differing samples.
// Ports:
//   clk_ik  in   40 MHz GBT clock
//   rst_ir  in   synchronous active-high reset (output resets to 1 = no light)
//   los_i   in   raw SFP LOS pin, asynchronous
//   los_o   out  filtered LOS
// ---------------------------------------------------------------------------
module sfp_los_filter
    import sfp_link_supervisor_pkg::*;
#(
    parameter int unsigned LOS_FILTER_CYCLES = DEF_LOS_FILTER_CYCLES
) (
    input  logic clk_ik,
    input  logic rst_ir,
    input  logic los_i,
    output logic los_o
);

    localparam int unsigned      CNT_W    = $clog2(LOS_FILTER_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOS_FILTER_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             los_f_q, los_f_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter tracks how many consecutive samples disagree with the filtered
    // level; the sample that would make it reach LOS_FILTER_CYCLES flips it.
    always_comb begin
        los_f_d = los_f_q;
        cnt_d   = '0;
        if (sync_q != los_f_q) begin
            if (cnt_q == CNT_LAST) begin
                los_f_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_ik) begin
        if (rst_ir) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            los_f_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            meta_q  <= los_i;
            sync_q  <= meta_q;
            los_f_q <= los_f_d;
            cnt_q   <= cnt_d;
        end
    end

    assign los_o = los_f_q;

endmodule

// File: rtl/sfp_link_supervisor.sv
// ---------------------------------------------------------------------------
// sfp_link_supervisor
// Supervises the optical GBT link at the SFP end: filters LOS, drives SFP
// tx_disable / rate_select, sequences TX reset, wait-for-signal and
// wait-for-lock, and reports link-up / fault.
// Ports:
//   clk_ik         in   40 MHz GBT clock
//   rst_ir         in   synchronous active-high reset
//   enable_i       in   link enable (0 forces DISABLED)
//   los_i          in   SFP loss-of-signal, asynchronous, 1 = no light
//   rx_locked_i    in   GBT receiver frame lock
//   clear_count_i  in   single-cycle clear of loss_count_o
//   tx_disable_o   out  SFP transmitter disable
//   rate_select_o  out  SFP rate select, constant 0
//   link_reset_o   out  reset request to downstream reset synchronisers
//   link_up_o      out  link operational
//   fault_o        out  lock retries exhausted
//   loss_count_o   out  saturating count of UP->loss transitions
//   retry_count_o  out  current retry count (only with SFP_LINK_STATS_EN)
// Macro SFP_LINK_STATS_EN builds the loss counter, its clear and the retry
// count export; otherwise loss_count_o is 0 and clear_count_i is ignored.
// ---------------------------------------------------------------------------
module sfp_link_supervisor
    import sfp_link_supervisor_pkg::*;
#(
    parameter int unsigned LOS_FILTER_CYCLES   = DEF_LOS_FILTER_CYCLES,
    parameter int unsigned TX_DISABLE_CYCLES   = DEF_TX_DISABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                    clk_ik,
    input  logic                    rst_ir,
    input  logic                    enable_i,
    input  logic                    los_i,
    input  logic                    rx_locked_i,
    input  logic                    clear_count_i,
    output logic                    tx_disable_o,
    output logic                    rate_select_o,
    output logic                    link_reset_o,
    output logic                    link_up_o,
    output logic                    fault_o,
    output logic [LOSS_COUNT_W-1:0] loss_count_o
`ifdef SFP_LINK_STATS_EN
    ,
    output logic [7:0]              retry_count_o
`endif
);

    localparam int unsigned TX_W    = $clog2(TX_DISABLE_CYCLES) + 1;
    localparam int unsigned LOCK_W  = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES) + 1;

    localparam logic [TX_W-1:0]    TX_LAST   = TX_W'(TX_DISABLE_CYCLES - 1);
    localparam logic [LOCK_W-1:0]  LOCK_LAST = LOCK_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    logic               los_f;
    t_sfp_link_state    state_q, state_d;
    logic [TX_W-1:0]    tx_cnt_q, tx_cnt_d;
    logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               loss_event;
    t_link_outputs      outs_q;

    sfp_los_filter #(
        .LOS_FILTER_CYCLES(LOS_FILTER_CYCLES)
    ) u_los_filter (
        .clk_ik(clk_ik),
        .rst_ir(rst_ir),
        .los_i (los_i),
        .los_o (los_f)
    );

    // Both timers default to zero, so they restart on every state change and
    // only count while their own state holds.
    always_comb begin
        state_d    = state_q;
        tx_cnt_d   = '0;
        lock_cnt_d = '0;
        retry_d    = retry_q;
        loss_event = 1'b0;
        if (!enable_i) begin
            state_d = DISABLED;
            retry_d = '0;
        end else begin
            case (state_q)
                DISABLED: state_d = TX_RESET;
                TX_RESET: begin
                    if (tx_cnt_q == TX_LAST) begin
                        state_d = WAIT_SIGNAL;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 1'b1;
                    end
                end
                WAIT_SIGNAL: begin
                    if (!los_f) begin
                        state_d = WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    if (rx_locked_i) begin
                        state_d = UP;
                        retry_d = '0;
                    end else if (los_f) begin
                        state_d = WAIT_SIGNAL;
                    end else if (lock_cnt_q == LOCK_LAST) begin
                        retry_d = retry_q + 1'b1;
                        state_d = (retry_d == RETRY_MAX) ? FAULT : TX_RESET;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end
                UP: begin
                    if (los_f || !rx_locked_i) begin
                        state_d    = TX_RESET;
                        loss_event = 1'b1;
                    end
                end
                FAULT:   state_d = FAULT;
                default: state_d = DISABLED;
            endcase
        end
    end

    // Outputs are decoded from the next state so they settle on the same
    // edge that commits the transition.
    always_ff @(posedge clk_ik) begin
        if (rst_ir) begin
            state_q    <= DISABLED;
            tx_cnt_q   <= '0;
            lock_cnt_q <= '0;
            retry_q    <= '0;
            outs_q     <= decode_outputs(DISABLED);
        end else begin
            state_q    <= state_d;
            tx_cnt_q   <= tx_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            retry_q    <= retry_d;
            outs_q     <= decode_outputs(state_d);
        end
    end

    assign tx_disable_o  = outs_q.tx_disable;
    assign link_reset_o  = outs_q.link_reset;
    assign link_up_o     = outs_q.link_up;
    assign fault_o       = outs_q.fault;
    assign rate_select_o = 1'b0;

`ifdef SFP_LINK_STATS_EN
    logic [LOSS_COUNT_W-1:0] loss_cnt_q, loss_cnt_d;

    // A clear in the same cycle as a loss wins.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (clear_count_i) begin
            loss_cnt_d = '0;
        end else if (loss_event && (loss_cnt_q != '1)) begin
            loss_cnt_d = loss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_ik) begin
        if (rst_ir) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign loss_count_o  = loss_cnt_q;
    assign retry_count_o = 8'(retry_q);
`else
    logic unused_stats;
    assign unused_stats = clear_count_i ^ loss_event;
    assign loss_count_o = '0;
`endif

endmodule

// File: tb/tb_sfp_link_supervisor.sv
module tb_sfp_link_supervisor;
    import sfp_link_supervisor_pkg::*;

`ifdef SFP_LINK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        enable;
    logic        los;
    logic        rx_locked;
    logic        clear_count;
    logic        tx_disable_o;
    logic        rate_select_o;
    logic        link_reset_o;
    logic        link_up_o;
    logic        fault_o;
    logic [15:0] loss_count_o;
`ifdef SFP_LINK_STATS_EN
    logic [7:0]  retry_count_o;
`endif

    int total = 0;
    int bad   = 0;

    sfp_link_supervisor #(
        .LOS_FILTER_CYCLES  (8),
        .TX_DISABLE_CYCLES  (4),
        .LOCK_TIMEOUT_CYCLES(32),
        .MAX_RETRIES        (2)
    ) dut (
        .clk_ik       (clk),
        .rst_ir       (rst),
        .enable_i     (enable),
        .los_i        (los),
        .rx_locked_i  (rx_locked),
        .clear_count_i(clear_count),
        .tx_disable_o (tx_disable_o),
        .rate_select_o(rate_select_o),
        .link_reset_o (link_reset_o),
        .link_up_o    (link_up_o),
        .fault_o      (fault_o),
        .loss_count_o (loss_count_o)
`ifdef SFP_LINK_STATS_EN
        ,
        .retry_count_o(retry_count_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n active edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk1({tag, "_txdis"}, tx_disable_o, 1'b1);
        chk1({tag, "_lrst"}, link_reset_o, 1'b1);
        chk1({tag, "_rate"}, rate_select_o, 1'b0);
        chk1({tag, "_up"}, link_up_o, 1'b0);
        chk1({tag, "_fault"}, fault_o, 1'b0);
        chkw({tag, "_loss"}, loss_count_o, 16'h0000);
        chkw({tag, "_state"}, 16'(dut.state_q), 16'(DISABLED));
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; los = 1'b0; rx_locked = 1'b0; clear_count = 1'b0;
        step(3);
        chk_reset_values("reset");
        rst = 1'b0;
        // Let the filtered LOS settle low (released reset + 2 + 8 edges).
        step(12);
        chk1("disabled_txdis", tx_disable_o, 1'b1);

        // ---- bring-up ----
        enable = 1'b1;
        step(1);
        chk1("bu_txdis_c1", tx_disable_o, 1'b1);
        step(3);
        chk1("bu_txdis_c4", tx_disable_o, 1'b1);
        step(1);
        chk1("bu_txdis_off", tx_disable_o, 1'b0);
        chk1("bu_lrst_ws", link_reset_o, 1'b1);
        step(1);
        chk1("bu_lrst_wl", link_reset_o, 1'b0);
        chk1("bu_up_wl", link_up_o, 1'b0);
        step(10);
        rx_locked = 1'b1;
        step(1);
        chk1("bu_up", link_up_o, 1'b1);
        chk1("bu_up_lrst", link_reset_o, 1'b0);
        chk1("bu_up_txdis", tx_disable_o, 1'b0);

        // ---- glitch rejection: 5-cycle LOS pulse ----
        los = 1'b1;
        step(5);
        los = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk1("glitch_up", link_up_o, 1'b1);
        end
        chkw("glitch_loss", loss_count_o, 16'h0000);

        // ---- real loss: LOS held 20 cycles ----
        los = 1'b1;
        step(10);
        chk1("loss_up_e10", link_up_o, 1'b1);
        step(1);
        chk1("loss_up_e11", link_up_o, 1'b0);
        chk1("loss_lrst_e11", link_reset_o, 1'b1);
        chk1("loss_txdis_e11", tx_disable_o, 1'b1);
        chkw("loss_count1", loss_count_o, STATS ? 16'd1 : 16'd0);
        step(3);
        chk1("loss_txdis_e14", tx_disable_o, 1'b1);
        step(1);
        chk1("loss_txdis_e15", tx_disable_o, 1'b0);
        chk1("loss_lrst_ws", link_reset_o, 1'b1);
        step(5);
        los = 1'b0;
        step(10);
        chk1("relock_lrst_ws", link_reset_o, 1'b1);
        step(1);
        chk1("relock_lrst_wl", link_reset_o, 1'b0);
        chk1("relock_up_wl", link_up_o, 1'b0);
        step(1);
        chk1("relock_up", link_up_o, 1'b1);

        // ---- lock timeout -> FAULT ----
        rx_locked = 1'b0;
        step(1);
        chk1("to_up_drop", link_up_o, 1'b0);
        chkw("to_loss_count2", loss_count_o, STATS ? 16'd2 : 16'd0);
        step(5);
        chk1("to_w1_start", link_reset_o, 1'b0);
        step(31);
        chk1("to_w1_end_lrst", link_reset_o, 1'b0);
        chk1("to_w1_end_txdis", tx_disable_o, 1'b0);
        step(1);
        chk1("to_retry1_lrst", link_reset_o, 1'b1);
        chk1("to_retry1_txdis", tx_disable_o, 1'b1);
        chk1("to_retry1_fault", fault_o, 1'b0);
`ifdef SFP_LINK_STATS_EN
        chkw("to_retry1_cnt", 16'(retry_count_o), 16'd1);
`endif
        step(4);
        chk1("to_ws2_txdis", tx_disable_o, 1'b0);
        step(1);
        chk1("to_w2_start", link_reset_o, 1'b0);
        step(31);
        chk1("to_w2_end_lrst", link_reset_o, 1'b0);
        chk1("to_w2_end_fault", fault_o, 1'b0);
        step(1);
        chk1("to_fault", fault_o, 1'b1);
        chk1("to_fault_txdis", tx_disable_o, 1'b1);
        chk1("to_fault_lrst", link_reset_o, 1'b1);
        chk1("to_fault_up", link_up_o, 1'b0);
`ifdef SFP_LINK_STATS_EN
        chkw("to_retry2_cnt", 16'(retry_count_o), 16'd2);
`endif
        step(5);
        chk1("to_fault_hold", fault_o, 1'b1);
        enable = 1'b0;
        step(1);
        chk1("to_fault_clr", fault_o, 1'b0);
        chk1("to_dis_txdis", tx_disable_o, 1'b1);
        chkw("to_dis_state", 16'(dut.state_q), 16'(DISABLED));
`ifdef SFP_LINK_STATS_EN
        chkw("to_retry_clr", 16'(retry_count_o), 16'd0);
`endif

        // ---- counter edge cases ----
        rx_locked = 1'b1;
        enable = 1'b1;
        step(7);
        chk1("cnt_up1", link_up_o, 1'b1);
`ifdef SFP_LINK_STATS_EN
        force dut.loss_cnt_q = 16'hFFFF;
        step(1);
        release dut.loss_cnt_q;
        chkw("cnt_preload", loss_count_o, 16'hFFFF);
`endif
        rx_locked = 1'b0;
        step(1);
        chk1("cnt_sat_up", link_up_o, 1'b0);
        chkw("cnt_sat", loss_count_o, STATS ? 16'hFFFF : 16'h0000);
        rx_locked = 1'b1;
        step(6);
        chk1("cnt_up2", link_up_o, 1'b1);
        rx_locked = 1'b0;
        clear_count = 1'b1;
        step(1);
        clear_count = 1'b0;
        chk1("cnt_clr_up", link_up_o, 1'b0);
        chkw("cnt_clr_wins", loss_count_o, 16'h0000);

        // ---- reset in the 2nd cycle of TX_RESET ----
        enable = 1'b0;
        step(1);
        enable = 1'b1;
        step(2);
        chk1("rst_txr_txdis", tx_disable_o, 1'b1);
        chkw("rst_txr_state", 16'(dut.state_q), 16'(TX_RESET));
        rst = 1'b1;
        step(1);
        chk_reset_values("rst_txr");
`ifdef SFP_LINK_STATS_EN
        chkw("rst_txr_retry", 16'(retry_count_o), 16'd0);
`endif
        rst = 1'b0;
        enable = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
